// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider with 50% duty for odd and even ratios.
// Ratio changes are accepted by handshake and applied only on a period boundary.
module clk_div_ctrl #(
    parameter int DIV_W   = 4,
    parameter int DIV_RST = 5
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clkout,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_LOAD  = 2'd3;

    logic [1:0]       state_q,    state_d;
    logic [DIV_W-1:0] cnt_q,      cnt_d;
    logic [DIV_W-1:0] cur_div_q,  cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_q,     pend_d;
    logic             cfg_err_q,  cfg_err_d;
    logic             pos_q,      pos_d;
    logic             neg_q;

    logic xfer;
    logic cfg_legal;
    logic last;

    assign cfg_ready = (state_q == S_IDLE) || (state_q == S_RUN);
    assign busy      = (state_q == S_DRAIN) || (state_q == S_LOAD);
    assign xfer      = cfg_valid && cfg_ready;
    assign cfg_legal = cfg_div > DIV_W'(1);
    assign last      = cnt_q == (cur_div_q - DIV_W'(1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        cfg_err_d  = xfer && !cfg_legal;
        case (state_q)
            S_IDLE: begin
                if (xfer && cfg_legal) cur_div_d = cfg_div;
                if (enable) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = last ? '0 : cnt_q + DIV_W'(1);
                if (xfer && cfg_legal) begin
                    pend_div_d = cfg_div;
                    pend_d     = 1'b1;
                    state_d    = S_DRAIN;
                end else if (!enable) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last) state_d = S_LOAD;
                else      cnt_d   = cnt_q + DIV_W'(1);
            end
            S_LOAD: begin
                if (pend_q) cur_div_d = pend_div_q;
                pend_d  = 1'b0;
                state_d = enable ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // pos tracks the next count so it is aligned with the registered cnt
        pos_d = ((state_d == S_RUN) || (state_d == S_DRAIN)) &&
                (cnt_d < (cur_div_d >> 1));
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_div_q  <= DIV_W'(DIV_RST);
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            pos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            cfg_err_q  <= cfg_err_d;
            pos_q      <= pos_d;
        end
    end

    // Half-cycle delayed copy of pos stretches the high time by 0.5 for odd ratios
    always_ff @(negedge clkin or posedge rst) begin
        if (rst) neg_q <= 1'b0;
        else     neg_q <= pos_q;
    end

    assign clkout  = cur_div_q[0] ? (pos_q | neg_q) : pos_q;
    assign cfg_err = cfg_err_q;
    assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: waveforms sampled every half clkin period.
module tb_clk_div_ctrl;

    logic       clkin = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       clkout;
    logic [3:0] cur_div;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    clk_div_ctrl #(.DIV_W(4), .DIV_RST(5)) dut (
        .clkin     (clkin),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clkout    (clkout),
        .cur_div   (cur_div),
        .busy      (busy)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    // Record clkout in the high and low phase of n consecutive clkin cycles
    task automatic wave(input int n, output logic [63:0] w);
        w = '0;
        for (int i = 0; i < n; i++) begin
            w = {w[62:0], clkout};
            @(negedge clkin);
            #1;
            w = {w[62:0], clkout};
            tick();
        end
    endtask

    logic [63:0] w;

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = 4'd0;
        #1;
        chk("rst_clkout", 64'(clkout), 64'd0);
        chk("rst_cur_div", 64'(cur_div), 64'd5);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_err", 64'(cfg_err), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("idle_clkout", 64'(clkout), 64'd0);

        // ratio 5 from reset
        enable = 1'b1;
        tick();
        wave(10, w);
        chk("wave_div5", w, 64'b11111000001111100000);

        // illegal ratio 1
        cfg_valid = 1'b1; cfg_div = 4'd1;
        chk("ready_run", 64'(cfg_ready), 64'd1);
        tick();
        cfg_valid = 1'b0;
        chk("err_pulse_1", 64'(cfg_err), 64'd1);
        chk("err_cur_div", 64'(cur_div), 64'd5);
        chk("err_busy", 64'(busy), 64'd0);
        tick();
        chk("err_clear", 64'(cfg_err), 64'd0);
        wave(5, w);
        chk("wave_after_err", w, 64'b1000001111);

        // switch 5 -> 4 at cnt 2
        cfg_valid = 1'b1; cfg_div = 4'd4;
        tick();
        cfg_valid = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_ready", 64'(cfg_ready), 64'd0);
        chk("drain_cur_div", 64'(cur_div), 64'd5);
        wave(11, w);
        chk("wave_5to4", w, 64'b0000001111000011110000);
        chk("div4_cur_div", 64'(cur_div), 64'd4);
        chk("div4_busy", 64'(busy), 64'd0);

        // switch 4 -> 7, then drop enable in RUN
        cfg_valid = 1'b1; cfg_div = 4'd7;
        tick();
        cfg_valid = 1'b0;
        repeat (4) tick();
        chk("div7_cur_div", 64'(cur_div), 64'd7);
        tick();
        enable = 1'b0;
        wave(9, w);
        chk("wave_div7_stop", w, 64'b111110000000000000);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_ready", 64'(cfg_ready), 64'd1);
        enable = 1'b1;
        tick();
        wave(7, w);
        chk("wave_div7_restart", w, 64'b11111110000000);

        // ratio 3 offered, enable dropped in DRAIN
        cfg_valid = 1'b1; cfg_div = 4'd3;
        tick();
        cfg_valid = 1'b0;
        enable = 1'b0;
        chk("d3_busy", 64'(busy), 64'd1);
        repeat (6) tick();
        chk("d3_load_busy", 64'(busy), 64'd1);
        tick();
        chk("d3_cur_div", 64'(cur_div), 64'd3);
        chk("d3_idle_ready", 64'(cfg_ready), 64'd1);
        chk("d3_idle_busy", 64'(busy), 64'd0);
        chk("d3_idle_clkout", 64'(clkout), 64'd0);
        enable = 1'b1;
        tick();
        wave(6, w);
        chk("wave_div3", w, 64'b111000111000);

        // illegal ratio 0
        cfg_valid = 1'b1; cfg_div = 4'd0;
        tick();
        cfg_valid = 1'b0;
        chk("err_pulse_0", 64'(cfg_err), 64'd1);
        chk("err0_cur_div", 64'(cur_div), 64'd3);

        // reset in DRAIN while clkout is high
        tick();
        cfg_valid = 1'b1; cfg_div = 4'd6;
        tick();
        cfg_valid = 1'b0;
        chk("rd_busy", 64'(busy), 64'd1);
        chk("rd_clkout_hi", 64'(clkout), 64'd1);
        rst = 1'b1;
        #1;
        chk("rd_clkout", 64'(clkout), 64'd0);
        chk("rd_cur_div", 64'(cur_div), 64'd5);
        chk("rd_busy_clr", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();
        chk("rd_after_cur_div", 64'(cur_div), 64'd5);
        chk("rd_after_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
